// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg: constants, capture FSM states and duty saturation shared by PWM logic.
// Rev 1.0
// ============================================================================
package pwm_pkg;

   localparam int PWM_PERIOD = 246;
   localparam int DUTY_W     = 8;

   typedef enum logic [1:0] {
      ARM_LOW   = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } cap_state_e;

   function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] ticks);
      return (ticks > 32'd255) ? {DUTY_W{1'b1}} : ticks[DUTY_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// pwm_sync_edge: two-flop synchronizer plus previous-level register for edge detect.
// Rev 1.0
// ============================================================================
module pwm_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic pwm_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= pwm_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;
   assign fall_o  = ~sync2_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture: measures high time, period and saturated duty of a PWM input.
// Rev 1.0
// ============================================================================
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_ticks,
   output logic [CNT_W-1:0]  period_ticks,
   output logic [DUTY_W-1:0] duty_out,
   output logic              sample_valid,
   output logic              stuck_high,
   output logic              stuck_low
);

   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic level;
   logic rise;
   logic fall;

   pwm_sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .pwm_i   (pwm_in),
      .level_o (level),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   cap_state_e        state_q, state_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  high_q, high_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              valid_q, valid_d;
   logic              sthi_q, sthi_d;
   logic              stlo_q, stlo_d;
   logic [1:0]        prime_q;
   logic              timeout;

   // Synchronizer flops start at 0, so its level is not trusted until it has refilled.
   always_ff @(posedge clk) begin
      if (reset) begin
         prime_q <= 2'b00;
      end else begin
         prime_q <= {prime_q[0], 1'b1};
      end
   end

   // The count would hit TIMEOUT on this cycle.
   assign timeout = (pcnt_q >= TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARM_LOW;
         hcnt_q   <= '0;
         pcnt_q   <= '0;
         high_q   <= '0;
         period_q <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         sthi_q   <= 1'b0;
         stlo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         pcnt_q   <= pcnt_d;
         high_q   <= high_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         sthi_q   <= sthi_d;
         stlo_q   <= stlo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      pcnt_d   = pcnt_q;
      high_d   = high_q;
      period_d = period_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      sthi_d   = sthi_q;
      stlo_d   = stlo_q;

      case (state_q)
         ARM_LOW: begin
            if (prime_q[1] && !level) begin
               state_d = WAIT_RISE;
            end
         end

         WAIT_RISE: begin
            if (rise) begin
               state_d = HIGH;
               hcnt_d  = ONE;
               pcnt_d  = ONE;
            end else if (timeout && level) begin
               state_d  = HIGH;
               high_d   = TO_VAL;
               period_d = TO_VAL;
               duty_d   = {DUTY_W{1'b1}};
               sthi_d   = 1'b1;
               valid_d  = 1'b1;
               hcnt_d   = '0;
               pcnt_d   = '0;
            end else if (timeout) begin
               high_d   = '0;
               period_d = TO_VAL;
               duty_d   = '0;
               stlo_d   = 1'b1;
               valid_d  = 1'b1;
               pcnt_d   = '0;
            end else begin
               pcnt_d = pcnt_q + ONE;
            end
         end

         HIGH: begin
            if (fall) begin
               state_d = LOW;
               pcnt_d  = sthi_q ? ONE : (pcnt_q + ONE);
            end else if (timeout) begin
               high_d   = TO_VAL;
               period_d = TO_VAL;
               duty_d   = {DUTY_W{1'b1}};
               sthi_d   = 1'b1;
               valid_d  = 1'b1;
               hcnt_d   = '0;
               pcnt_d   = '0;
            end else begin
               hcnt_d = hcnt_q + ONE;
               pcnt_d = pcnt_q + ONE;
            end
         end

         LOW: begin
            if (rise) begin
               state_d  = HIGH;
               high_d   = hcnt_q;
               period_d = pcnt_q;
               duty_d   = sat_duty(32'(hcnt_q));
               sthi_d   = 1'b0;
               stlo_d   = 1'b0;
               valid_d  = 1'b1;
               hcnt_d   = ONE;
               pcnt_d   = ONE;
            end else if (timeout) begin
               state_d  = WAIT_RISE;
               high_d   = '0;
               period_d = TO_VAL;
               duty_d   = '0;
               stlo_d   = 1'b1;
               valid_d  = 1'b1;
               pcnt_d   = '0;
            end else begin
               pcnt_d = pcnt_q + ONE;
            end
         end

         default: state_d = ARM_LOW;
      endcase
   end

   assign high_ticks   = high_q;
   assign period_ticks = period_q;
   assign duty_out     = duty_q;
   assign sample_valid = valid_q;
   assign stuck_high   = sthi_q;
   assign stuck_low    = stlo_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// tb_pwm_capture: directed stimulus with a queue-based scoreboard for pwm_capture.
// Rev 1.0
// ============================================================================
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int CNT_W = 16;
   localparam int TO    = 1024;

   logic             clk;
   logic             reset;
   logic             pwm_in;
   logic [CNT_W-1:0] high_ticks;
   logic [CNT_W-1:0] period_ticks;
   logic [7:0]       duty_out;
   logic             sample_valid;
   logic             stuck_high;
   logic             stuck_low;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .pwm_in       (pwm_in),
      .high_ticks   (high_ticks),
      .period_ticks (period_ticks),
      .duty_out     (duty_out),
      .sample_valid (sample_valid),
      .stuck_high   (stuck_high),
      .stuck_low    (stuck_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int high;
      int period;
      int duty;
      int shi;
      int slo;
      bit wild;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_since = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic push(input int h, input int p, input int d, input int shi,
                       input int slo, input bit wild, input int gap);
      exp_t e;
      e.high = h; e.period = p; e.duty = d; e.shi = shi; e.slo = slo;
      e.wild = wild; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: gap is the number of clocks since the previous report.
   always @(negedge clk) begin
      if (reset) begin
         cyc_since = 0;
      end else begin
         cyc_since++;
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_report: high=%0d period=%0d duty=%0d, expected no report (t=%0t)",
                        high_ticks, period_ticks, duty_out, $time);
            end else begin
               mon_e = exp_q.pop_front();
               if (!mon_e.wild) begin
                  chk("high_ticks", int'(high_ticks), mon_e.high);
                  chk("period_ticks", int'(period_ticks), mon_e.period);
                  chk("duty_out", int'(duty_out), mon_e.duty);
               end
               chk("stuck_high", int'(stuck_high), mon_e.shi);
               chk("stuck_low", int'(stuck_low), mon_e.slo);
               if (mon_e.gap >= 0) chk("report_gap", cyc_since, mon_e.gap);
            end
            cyc_since = 0;
         end
      end
   end

   task automatic drive(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gen(input int thr, input int nper);
      int hi;
      hi = (thr >= PWM_PERIOD) ? PWM_PERIOD : thr;
      for (int p = 0; p < nper; p++) begin
         if (hi > 0) drive(1'b1, hi);
         if (PWM_PERIOD - hi > 0) drive(1'b0, PWM_PERIOD - hi);
      end
   endtask

   task automatic do_reset(input logic lvl, input int n);
      reset  = 1'b1;
      pwm_in = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      chk({tag, "_high"}, int'(high_ticks), 0);
      chk({tag, "_period"}, int'(period_ticks), 0);
      chk({tag, "_duty"}, int'(duty_out), 0);
      chk({tag, "_valid"}, int'(sample_valid), 0);
      chk({tag, "_stuck_high"}, int'(stuck_high), 0);
      chk({tag, "_stuck_low"}, int'(stuck_low), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      pwm_in = 1'b0;

      // Reset state
      do_reset(1'b0, 5);
      reset = 1'b1;
      check_zero("reset");

      // Generator loopback, threshold 100
      do_reset(1'b0, 4);
      drive(1'b0, 10);
      push(100, 246, 100, 0, 0, 0, -1);
      push(100, 246, 100, 0, 0, 0, 246);
      push(100, 246, 100, 0, 0, 0, 246);
      gen(100, 4);
      chk("t1_pending", exp_q.size(), 0);

      // Constant low: periodic stuck_low reports
      do_reset(1'b0, 4);
      push(0, TO, 0, 0, 1, 0, -1);
      push(0, TO, 0, 0, 1, 0, TO);
      push(0, TO, 0, 0, 1, 0, TO);
      drive(1'b0, 3 * TO + 40);
      chk("t2_pending", exp_q.size(), 0);

      // Constant high, then threshold 50 clears stuck_high
      do_reset(1'b0, 4);
      drive(1'b0, 10);
      push(TO, TO, 255, 1, 0, 0, -1);
      push(0, 0, 0, 0, 0, 1, -1);
      push(50, 246, 50, 0, 0, 0, 246);
      gen(250, 5);
      gen(50, 3);
      chk("t3_pending", exp_q.size(), 0);

      // Input high through reset release
      do_reset(1'b1, 4);
      drive(1'b1, 50);
      drive(1'b0, 50);
      drive(1'b1, 30);
      drive(1'b0, 50);
      push(30, 80, 30, 0, 0, 0, -1);
      drive(1'b1, 30);
      drive(1'b0, 50);
      chk("t4_pending", exp_q.size(), 0);

      // Reset mid-HIGH discards the partial measurement
      do_reset(1'b0, 4);
      drive(1'b0, 20);
      drive(1'b1, 40);
      drive(1'b0, 60);
      push(40, 100, 40, 0, 0, 0, -1);
      drive(1'b1, 40);
      chk("t5_pre_pending", exp_q.size(), 0);
      reset = 1'b1;
      drive(1'b1, 3);
      check_zero("midreset");
      reset = 1'b0;
      drive(1'b1, 20);
      drive(1'b0, 60);
      drive(1'b1, 70);
      drive(1'b0, 90);
      push(70, 160, 70, 0, 0, 0, -1);
      drive(1'b1, 10);
      drive(1'b0, 10);
      chk("t5_pending", exp_q.size(), 0);

      // Glitches and a long high with duty saturation
      do_reset(1'b0, 4);
      drive(1'b0, 10);
      push(1, 300, 1, 0, 0, 0, -1);
      push(1, 300, 1, 0, 0, 0, 300);
      push(400, 500, 255, 0, 0, 0, 500);
      drive(1'b1, 1);
      drive(1'b0, 299);
      drive(1'b1, 1);
      drive(1'b0, 299);
      drive(1'b1, 400);
      drive(1'b0, 100);
      drive(1'b1, 1);
      drive(1'b0, 20);
      chk("t6_pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
